shift_register: RTL and testbench

SHIFT_REGISTER -- requirements
Module: shift_register

---
 rtl/shift_register.sv | 39 +++
 tb/tb_shift_register.sv | 127 ++++++++++++
 2 files changed

// File: rtl/shift_register.sv
// Parallel-load / serial-shift register, shifting toward the MSB.
// Q drives o_Qout directly; o_Sout taps the MSB of Q.
module shift_register #(
  parameter int BW_DATA = 8
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic [BW_DATA-1:0] i_D,
  input  logic               i_Load,
  input  logic               i_Sin,
  output logic [BW_DATA-1:0] o_Qout,
  output logic               o_Sout
);

  logic [BW_DATA-1:0] q_q;
  logic [BW_DATA-1:0] q_d;

  // Every non-reset edge either loads or shifts; there is no hold state.
  always_comb begin
    q_d = q_q;
    if (i_Load) begin
      q_d = i_D;
    end else begin
      q_d = {q_q[BW_DATA-2:0], i_Sin};
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign o_Qout = q_q;
  assign o_Sout = q_q[BW_DATA-1];

endmodule

// File: tb/tb_shift_register.sv
// Directed bench for shift_register (BW_DATA=8): reset, serial-in, parallel-out,
// level-sensitive load, reset mid-shift and a short random run against a reference model.
module tb_shift_register;

  localparam int BW = 8;

  logic          i_Clk = 1'b0;
  logic          i_Rst;
  logic [BW-1:0] i_D;
  logic          i_Load;
  logic          i_Sin;
  logic [BW-1:0] o_Qout;
  logic          o_Sout;

  int n_checks = 0;
  int n_fail   = 0;

  shift_register #(.BW_DATA(BW)) dut (
    .i_Clk  (i_Clk),
    .i_Rst  (i_Rst),
    .i_D    (i_D),
    .i_Load (i_Load),
    .i_Sin  (i_Sin),
    .o_Qout (o_Qout),
    .o_Sout (o_Sout)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick;
    @(posedge i_Clk);
    #1;
  endtask

  initial begin
    logic [BW-1:0] bits;
    logic [BW-1:0] v;
    logic [BW-1:0] m;
    logic [BW-1:0] loads [3];

    // Reset for two edges while load is asserted with all ones.
    i_Rst = 1'b1; i_Load = 1'b1; i_D = 8'hFF; i_Sin = 1'b1;
    tick;
    tick;
    check_eq("reset_qout", 64'(o_Qout), 64'h00);
    check_eq("reset_sout", 64'(o_Sout), 64'h0);

    // Serial-in 1,0,1,1,0,0,1,0 (first bit ends up at the MSB).
    i_Rst = 1'b0; i_Load = 1'b0; i_D = 8'hFF;
    bits = 8'b10110010;
    for (int i = 0; i < BW; i++) begin
      i_Sin = bits[BW-1-i];
      tick;
    end
    check_eq("s2p_qout", 64'(o_Qout), 64'hB2);
    check_eq("s2p_sout", 64'(o_Sout), 64'h1);

    // Parallel-in 0xA5, then serialise MSB first with zeros shifted in.
    i_Load = 1'b1; i_D = 8'hA5; i_Sin = 1'b1;
    tick;
    check_eq("p2s_load", 64'(o_Qout), 64'hA5);
    check_eq("p2s_bit0", 64'(o_Sout), 64'h1);
    i_Load = 1'b0; i_Sin = 1'b0; i_D = 8'hFF;
    v = 8'hA5;
    for (int i = 1; i < BW; i++) begin
      tick;
      check_eq($sformatf("p2s_bit%0d", i), 64'(o_Sout), 64'(v[BW-1-i]));
    end
    tick;
    check_eq("p2s_after", 64'(o_Sout), 64'h0);
    check_eq("p2s_qout_empty", 64'(o_Qout), 64'h00);

    // Load held high: reloads each edge, serial input ignored.
    loads[0] = 8'h12; loads[1] = 8'h34; loads[2] = 8'h56;
    i_Load = 1'b1; i_Sin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_D = loads[i];
      tick;
      check_eq($sformatf("hold_load%0d", i), 64'(o_Qout), 64'(loads[i]));
    end

    // Load 0x3C, shift ones three times, then reset mid-serialisation.
    i_D = 8'h3C;
    tick;
    check_eq("mid_load", 64'(o_Qout), 64'h3C);
    i_Load = 1'b0; i_Sin = 1'b1;
    tick;
    check_eq("mid_shift1", 64'(o_Qout), 64'h79);
    tick;
    check_eq("mid_shift2", 64'(o_Qout), 64'hF3);
    tick;
    check_eq("mid_shift3", 64'(o_Qout), 64'hE7);
    i_Rst = 1'b1; i_Load = 1'b1; i_D = 8'hAA;
    tick;
    check_eq("mid_reset_qout", 64'(o_Qout), 64'h00);
    check_eq("mid_reset_sout", 64'(o_Sout), 64'h0);
    i_Rst = 1'b0; i_Load = 1'b0; i_Sin = 1'b1;
    tick;
    check_eq("resume_shift", 64'(o_Qout), 64'h01);

    // Random shifts, one load, random shifts, against a reference model.
    m = 8'h01;
    for (int i = 0; i < 41; i++) begin
      i_D   = BW'($urandom);
      i_Sin = 1'($urandom);
      i_Load = (i == 20);
      tick;
      if (i == 20) m = i_D;
      else         m = {m[BW-2:0], i_Sin};
      check_eq($sformatf("rand_qout%0d", i), 64'(o_Qout), 64'(m));
      check_eq($sformatf("rand_sout%0d", i), 64'(o_Sout), 64'(m[BW-1]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
